// File: rtl/tis_node_gen2.sv
// TIS-100 style execution node: ACC/BAK, loadable program RAM and NPORTS blocking
// valid/ready neighbour ports (with ANY), tileable by joining out_* to in_* of neighbours.
module tis_node_gen2 #(
  parameter int DATA_W = 8,
  parameter int PROG_D = 16,
  parameter int NPORTS = 4,
  localparam int AW = $clog2(PROG_D),
  localparam int IW = 10 + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     prog_we,
  input  logic [AW-1:0]            prog_addr,
  input  logic [IW-1:0]            prog_data,
  input  logic [AW-1:0]            prog_last,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  input  logic [NPORTS-1:0]        in_valid,
  output logic [NPORTS-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [AW-1:0]            pc,
  output logic [DATA_W-1:0]        acc,
  output logic                     blocked
);

  typedef enum logic {S_RUN, S_WRITE} state_t;

  localparam logic [3:0] OP_MOV = 4'd1, OP_SWP = 4'd2, OP_SAV = 4'd3, OP_ADD = 4'd4,
                         OP_SUB = 4'd5, OP_NEG = 4'd6, OP_JMP = 4'd7, OP_JEZ = 4'd8,
                         OP_JNZ = 4'd9, OP_JGZ = 4'd10, OP_JLZ = 4'd11, OP_JRO = 4'd12;

  localparam int SW = ((AW > DATA_W) ? AW : DATA_W) + 2;
  localparam int SMAX_I = 2 ** (DATA_W - 1) - 1;
  localparam logic signed [DATA_W:0] SMAX = (DATA_W + 1)'(SMAX_I);
  localparam logic signed [DATA_W:0] SMIN = -SMAX;

  logic [IW-1:0]     prog_mem [PROG_D];
  state_t            state_reg;
  logic [AW-1:0]     pc_reg;
  logic [DATA_W-1:0] acc_reg, bak_reg, out_reg;
  logic [3:0]        out_mask_reg;

  logic [IW-1:0]     instr;
  logic [3:0]        op;
  logic [2:0]        src, dst;
  logic [DATA_W-1:0] imm;

  // Ports are padded out to four so every port code decodes uniformly;
  // absent ports read as never-valid/never-ready and decode as NIL.
  logic [DATA_W-1:0] in_word [4];
  logic [3:0]        valid_pad, ready_pad, port_exist;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NPORTS) begin : g_real
        assign in_word[gi]    = in_data[gi*DATA_W +: DATA_W];
        assign valid_pad[gi]  = in_valid[gi];
        assign ready_pad[gi]  = out_ready[gi];
        assign port_exist[gi] = 1'b1;
      end else begin : g_none
        assign in_word[gi]    = '0;
        assign valid_pad[gi]  = 1'b0;
        assign ready_pad[gi]  = 1'b0;
        assign port_exist[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (prog_we && !run)
      prog_mem[prog_addr] <= prog_data;
  end

  assign instr = prog_mem[pc_reg];
  assign op    = instr[IW-1 -: 4];
  assign src   = instr[IW-5 -: 3];
  assign dst   = instr[IW-8 -: 3];
  assign imm   = instr[DATA_W-1:0];

  // ANY read picks the lowest-index valid port
  logic              any_hit;
  logic [DATA_W-1:0] any_data;
  logic [3:0]        any_onehot;
  always_comb begin
    any_hit    = 1'b0;
    any_data   = '0;
    any_onehot = '0;
    for (int k = 3; k >= 0; k--) begin
      if (valid_pad[k]) begin
        any_hit    = 1'b1;
        any_data   = in_word[k];
        any_onehot = 4'(1 << k);
      end
    end
  end

  logic              uses_src, src_ok, active;
  logic [DATA_W-1:0] src_val;
  logic [3:0]        rd_ready;
  always_comb begin
    uses_src = (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_JRO);
    src_val  = '0;
    src_ok   = 1'b1;
    rd_ready = '0;
    case (src)
      3'd0: src_val = imm;
      3'd1: src_val = acc_reg;
      3'd2: src_val = '0;
      3'd3: begin
        src_val  = any_data;
        src_ok   = any_hit;
        rd_ready = any_onehot;
      end
      default: begin
        if (port_exist[src[1:0]]) begin
          src_val  = in_word[src[1:0]];
          src_ok   = valid_pad[src[1:0]];
          rd_ready = 4'(1 << src[1:0]);
        end
      end
    endcase
  end

  assign active = (state_reg == S_RUN) && run;

  logic       stall_rd, accept, dst_port;
  logic [3:0] wr_mask;
  always_comb begin
    stall_rd = active && uses_src && !src_ok;
    accept   = (state_reg == S_WRITE) && |(out_mask_reg & ready_pad);
    wr_mask  = '0;
    if (dst == 3'd3)
      wr_mask = port_exist;
    else if (dst[2] && port_exist[dst[1:0]])
      wr_mask = 4'(1 << dst[1:0]);
    dst_port = |wr_mask;
  end

  assign in_ready  = (active && uses_src) ? rd_ready[NPORTS-1:0] : '0;
  assign blocked   = stall_rd || ((state_reg == S_WRITE) && !accept);
  assign out_valid = out_mask_reg[NPORTS-1:0];
  assign out_data  = out_reg;
  assign pc        = pc_reg;
  assign acc       = acc_reg;

  // Arithmetic is done one bit wider and clamped to the symmetric range
  logic signed [DATA_W:0] acc_ext, src_ext, add_raw, sub_raw, neg_raw;
  logic [DATA_W-1:0]      add_sat, sub_sat, neg_sat;

  function automatic logic [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
    if (v > SMAX)      return SMAX[DATA_W-1:0];
    else if (v < SMIN) return SMIN[DATA_W-1:0];
    else               return v[DATA_W-1:0];
  endfunction

  always_comb begin
    acc_ext = {acc_reg[DATA_W-1], acc_reg};
    src_ext = {src_val[DATA_W-1], src_val};
    add_raw = acc_ext + src_ext;
    sub_raw = acc_ext - src_ext;
    neg_raw = -acc_ext;
    add_sat = sat(add_raw);
    sub_sat = sat(sub_raw);
    neg_sat = sat(neg_raw);
  end

  logic [AW-1:0]        pc_seq, jmp_tgt, jro_tgt;
  logic signed [SW-1:0] jro_sum, last_ext;
  logic                 acc_zero, acc_neg, take_jump;
  always_comb begin
    pc_seq   = (pc_reg == prog_last) ? '0 : pc_reg + AW'(1);
    jmp_tgt  = (imm[AW-1:0] > prog_last) ? prog_last : imm[AW-1:0];
    jro_sum  = SW'(signed'({1'b0, pc_reg})) + SW'(signed'(src_val));
    last_ext = SW'(signed'({1'b0, prog_last}));
    if (jro_sum < 0)             jro_tgt = '0;
    else if (jro_sum > last_ext) jro_tgt = prog_last;
    else                         jro_tgt = jro_sum[AW-1:0];
    acc_zero = (acc_reg == '0);
    acc_neg  = acc_reg[DATA_W-1];
    case (op)
      OP_JMP:  take_jump = 1'b1;
      OP_JEZ:  take_jump = acc_zero;
      OP_JNZ:  take_jump = !acc_zero;
      OP_JGZ:  take_jump = !acc_zero && !acc_neg;
      OP_JLZ:  take_jump = acc_neg;
      default: take_jump = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_RUN;
      pc_reg       <= '0;
      acc_reg      <= '0;
      bak_reg      <= '0;
      out_reg      <= '0;
      out_mask_reg <= '0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (run && !stall_rd) begin
            case (op)
              OP_MOV: begin
                if (dst_port) begin
                  out_reg      <= src_val;
                  out_mask_reg <= wr_mask;
                  state_reg    <= S_WRITE;
                end else begin
                  if (dst == 3'd1) acc_reg <= src_val;
                  pc_reg <= pc_seq;
                end
              end
              OP_SWP: begin
                acc_reg <= bak_reg;
                bak_reg <= acc_reg;
                pc_reg  <= pc_seq;
              end
              OP_SAV: begin
                bak_reg <= acc_reg;
                pc_reg  <= pc_seq;
              end
              OP_ADD: begin
                acc_reg <= add_sat;
                pc_reg  <= pc_seq;
              end
              OP_SUB: begin
                acc_reg <= sub_sat;
                pc_reg  <= pc_seq;
              end
              OP_NEG: begin
                acc_reg <= neg_sat;
                pc_reg  <= pc_seq;
              end
              OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ:
                pc_reg <= take_jump ? jmp_tgt : pc_seq;
              OP_JRO:
                pc_reg <= jro_tgt;
              default:
                pc_reg <= pc_seq;
            endcase
          end
        end
        S_WRITE: begin
          if (accept) begin
            out_mask_reg <= '0;
            state_reg    <= S_RUN;
            pc_reg       <= pc_seq;
          end
        end
        default: state_reg <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_tis_node_gen2.sv
// Directed bench for tis_node_gen2 (DATA_W=8, PROG_D=16, NPORTS=4) with hand-computed results.
module tb_tis_node_gen2;

  logic        clk = 1'b0;
  logic        rst, run, prog_we;
  logic [3:0]  prog_addr, prog_last, pc;
  logic [17:0] prog_data;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  out_data, acc;
  logic        blocked;

  int n_cmp = 0;
  int n_bad = 0;

  tis_node_gen2 #(.DATA_W(8), .PROG_D(16), .NPORTS(4)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_last(prog_last), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .acc(acc), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [17:0] ins(input logic [3:0] op, input logic [2:0] s,
                                      input logic [2:0] d, input logic [7:0] imm);
    return {op, s, d, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold the node in reset with run low so the program RAM can be written
  task automatic hold();
    rst = 1'b1; run = 1'b0; in_valid = '0; out_ready = '0; in_data = '0;
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [17:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] last);
    prog_last = last;
    rst = 1'b0;
    run = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_last = '0; in_data = '0; in_valid = '0; out_ready = '0;
    @(negedge clk);
    in_valid = 4'b1111;
    #1;
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_acc", 32'(acc), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_in_ready_run0", 32'(in_ready), 32'h0);

    // 1: MOV 5,ACC; ADD 3; MOV ACC,P0
    hold();
    load(4'd0, ins(4'd1, 3'd0, 3'd1, 8'd5));
    load(4'd1, ins(4'd4, 3'd0, 3'd0, 8'd3));
    load(4'd2, ins(4'd1, 3'd1, 3'd4, 8'd0));
    go(4'd2);
    out_ready = 4'b0001;
    tick(); tick(); tick();
    check("t1_out_data", 32'(out_data), 32'h8);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    tick();
    check("t1_pc_wrap", 32'(pc), 32'h0);
    check("t1_out_valid_drop", 32'(out_valid), 32'h0);

    // 2: saturation
    hold();
    load(4'd0, ins(4'd1, 3'd0, 3'd1, 8'd120));
    load(4'd1, ins(4'd4, 3'd0, 3'd0, 8'd100));
    load(4'd2, ins(4'd1, 3'd0, 3'd1, 8'd0));
    load(4'd3, ins(4'd5, 3'd0, 3'd0, 8'd127));
    load(4'd4, ins(4'd5, 3'd0, 3'd0, 8'd127));
    load(4'd5, ins(4'd1, 3'd0, 3'd1, 8'h80));
    load(4'd6, ins(4'd6, 3'd0, 3'd0, 8'd0));
    go(4'd6);
    tick(); tick();
    check("t2_add_sat", 32'(acc), 32'h7F);
    tick(); tick();
    check("t2_sub_once", 32'(acc), 32'h81);
    tick();
    check("t2_sub_sat", 32'(acc), 32'h81);
    tick();
    check("t2_mov_min", 32'(acc), 32'h80);
    tick();
    check("t2_neg_min", 32'(acc), 32'h7F);

    // 3: blocking read on P1
    hold();
    load(4'd0, ins(4'd1, 3'd5, 3'd1, 8'd0));
    load(4'd1, ins(4'd0, 3'd0, 3'd0, 8'd0));
    go(4'd1);
    for (int i = 0; i < 5; i++) tick();
    check("t3_blocked", 32'(blocked), 32'h1);
    check("t3_pc_held", 32'(pc), 32'h0);
    check("t3_in_ready", 32'(in_ready), 32'h2);
    in_data = 32'h0000_2A00;
    in_valid = 4'b0010;
    #1;
    check("t3_unblocked", 32'(blocked), 32'h0);
    @(negedge clk);
    in_valid = '0;
    #1;
    check("t3_acc", 32'(acc), 32'h2A);
    check("t3_pc", 32'(pc), 32'h1);

    // 4: ANY read picks lowest valid
    hold();
    load(4'd0, ins(4'd1, 3'd3, 3'd1, 8'd0));
    go(4'd0);
    in_data = 32'h3300_1100;
    in_valid = 4'b1010;
    #1;
    check("t4_in_ready", 32'(in_ready), 32'h2);
    @(negedge clk);
    in_valid = '0;
    #1;
    check("t4_acc", 32'(acc), 32'h11);

    // 5: ANY write
    hold();
    load(4'd0, ins(4'd1, 3'd0, 3'd3, 8'd7));
    load(4'd1, ins(4'd0, 3'd0, 3'd0, 8'd0));
    go(4'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5_out_valid_wait", 32'(out_valid), 32'hF);
      check("t5_blocked_wait", 32'(blocked), 32'h1);
      check("t5_pc_wait", 32'(pc), 32'h0);
      if (i < 2) tick();
    end
    check("t5_out_data", 32'(out_data), 32'h7);
    out_ready = 4'b0100;
    #1;
    check("t5_accept_unblocked", 32'(blocked), 32'h0);
    @(negedge clk);
    out_ready = '0;
    #1;
    check("t5_pc_adv", 32'(pc), 32'h1);
    check("t5_out_valid_drop", 32'(out_valid), 32'h0);

    // 6: JRO clamps and conditional jumps
    hold();
    load(4'd0, ins(4'd0, 3'd0, 3'd0, 8'd0));
    load(4'd1, ins(4'd0, 3'd0, 3'd0, 8'd0));
    load(4'd2, ins(4'd12, 3'd0, 3'd0, 8'hF7));
    go(4'd5);
    tick(); tick();
    check("t6_pc2", 32'(pc), 32'h2);
    tick();
    check("t6_jro_neg_clamp", 32'(pc), 32'h0);

    hold();
    load(4'd0, ins(4'd12, 3'd0, 3'd0, 8'd20));
    go(4'd5);
    tick();
    check("t6_jro_pos_clamp", 32'(pc), 32'h5);

    hold();
    load(4'd0, ins(4'd8, 3'd0, 3'd0, 8'd3));
    go(4'd3);
    tick();
    check("t6_jez_taken", 32'(pc), 32'h3);

    hold();
    load(4'd0, ins(4'd9, 3'd0, 3'd0, 8'd3));
    go(4'd3);
    tick();
    check("t6_jnz_not_taken", 32'(pc), 32'h1);

    hold();
    load(4'd0, ins(4'd1, 3'd0, 3'd4, 8'd7));
    go(4'd3);
    tick();
    check("t6_write_pending", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'h0);
    check("t6_rst_out_data", 32'(out_data), 32'h0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
